// File: rtl/scan_timer.sv
`default_nettype none
// ============================================================================
//  Module   : scan_timer
//  Purpose  : Seven-segment refresh sequencer. Divides clk into digit slots,
//             blanks the leading edge of every slot, selects the BCD nibble
//             of the current digit, and double-buffers display updates so a
//             new value is only committed on a frame boundary.
//  Revision : 1.0  initial release
// ============================================================================
module scan_timer #(
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int NUM_DIGITS   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  output logic [1:0]              twobitcounter,
  output logic [3:0]              digit_bcd,
  output logic                    blank,
  output logic                    frame_done,
  output logic                    update_pending
);

  localparam int PRESC_W = $clog2(PRESCALE);
  localparam logic [PRESC_W-1:0] c_gap_last   = PRESC_W'(BLANK_CYCLES - 1);
  localparam logic [PRESC_W-1:0] c_slot_last  = PRESC_W'(PRESCALE - 1);
  localparam logic [1:0]         c_digit_last = 2'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SHOW = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PRESC_W-1:0]      presc_q, presc_d;
  logic [1:0]              digit_q, digit_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic                    valid_q, valid_d;
  logic                    frame_done_q, frame_done_d;
  logic                    wrap;

  // State register and buffers; reset clears everything, including pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      digit_q      <= '0;
      active_q     <= '0;
      pending_q    <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      digit_q      <= digit_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state: slot timing, digit advance, frame-boundary commit and loads.
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    digit_d      = digit_q;
    active_d     = active_q;
    pending_d    = pending_q;
    valid_d      = valid_q;
    frame_done_d = 1'b0;
    wrap         = 1'b0;

    case (state_q)
      IDLE: begin
        presc_d = '0;
        digit_d = '0;
        // While idle nothing is being scanned, so a load goes live directly.
        if (load) active_d = value;
        if (en)   state_d  = GAP;
      end
      GAP: begin
        presc_d = presc_q + PRESC_W'(1);
        if (presc_q == c_gap_last) state_d = SHOW;
      end
      SHOW: begin
        presc_d = presc_q + PRESC_W'(1);
        if (presc_q == c_slot_last) begin
          presc_d = '0;
          state_d = GAP;
          if (digit_q == c_digit_last) begin
            digit_d = '0;
            wrap    = 1'b1;
          end else begin
            digit_d = digit_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable overrides slot timing: no wrap, no frame pulse, no commit.
    if (state_q != IDLE && !en) begin
      state_d = IDLE;
      presc_d = '0;
      digit_d = '0;
      wrap    = 1'b0;
    end

    // Commit the old pending value first so a coincident load lands in
    // pending for the following frame.
    if (wrap) begin
      frame_done_d = 1'b1;
      if (valid_q) begin
        active_d = pending_q;
        valid_d  = 1'b0;
      end
    end

    if (state_q != IDLE && load) begin
      pending_d = value;
      valid_d   = 1'b1;
    end
  end

  // Nibble select for the digit currently on the anode.
  always_comb begin
    digit_bcd = 4'd0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (digit_q == 2'(d)) digit_bcd = active_q[4*d +: 4];
    end
  end

  assign twobitcounter  = digit_q;
  assign blank          = (state_q != SHOW);
  assign frame_done     = frame_done_q;
  assign update_pending = valid_q;

endmodule
`default_nettype wire

// File: doc/scan_timer.md
# scan_timer

Display refresh sequencer for the seven-segment display. It divides the system clock into digit slots and drives the 2-bit digit index `twobitcounter` that the anode decoder consumes. It also selects the BCD nibble for the current digit and blanks each slot's leading edge to suppress ghosting. Frame-synchronous double buffering applies display updates only at frame boundaries, so no update ever shows a mixed value.

## Interface
- PRESCALE, 100000: clock cycles per digit slot (1 kHz slot rate at 100 MHz); must be ≥ 4.
- BLANK_CYCLES, 1000: blanked cycles at the start of each slot; 1 ≤ BLANK_CYCLES < PRESCALE.
- NUM_DIGITS, 3: digits scanned, 2..4.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  scan enable; low forces idle and blank.
- load  in  1  one-cycle request to capture `value`.
- value  in  4*NUM_DIGITS  BCD digits; digit d occupies bits [4d+3:4d].
- twobitcounter  out  2  current digit index; feeds the anode decoder.
- digit_bcd  out  4  BCD nibble of the current digit from the active buffer.
- blank  out  1  high means the segment drivers must be off.
- frame_done  out  1  one-cycle pulse after the last digit slot completes.
- update_pending  out  1  pending buffer holds an uncommitted value.

## Operation
- State machine states:
  - IDLE:
    - Outputs `blank`=1, `twobitcounter`=0, prescaler=0.
    - Goes to GAP on the edge where `en`=1 is sampled; prescaler starts at 0.
  - GAP:
    - `blank`=1; prescaler increments each cycle.
    - Goes to SHOW when prescaler==BLANK_CYCLES-1.
  - SHOW:
    - `blank`=0; prescaler increments.
    - When prescaler==PRESCALE-1:
      - Prescaler goes to 0 and the state goes to GAP.
      - Digit index goes to digit+1, or wraps to 0 from NUM_DIGITS-1.
  - From GAP or SHOW, `en`=0 sampled goes to IDLE next cycle, with digit=0 and prescaler=0.
- Slot period is exactly PRESCALE cycles: BLANK_CYCLES blanked, then PRESCALE-BLANK_CYCLES shown. A frame is NUM_DIGITS×PRESCALE cycles.
- Buffers: `active` (displayed) and `pending` (with valid flag, output as `update_pending`).
  - `load` in IDLE: `active` takes `value` next cycle; `pending` untouched.
  - `load` in GAP/SHOW: `pending` takes `value`; valid goes to 1. A later load before commit overwrites it (last writer wins).
  - Commit happens on the wrap edge only, when digit goes from NUM_DIGITS-1 to 0. If valid, `active` takes `pending` and valid clears.
  - `load` on the same cycle as a wrap commit: the old pending is committed, the new value goes to `pending`, and valid stays 1.
- `frame_done`:
  - Registered; high for exactly the one cycle following each wrap edge.
  - Not asserted on entry to IDLE.
- `digit_bcd` = active[4×digit +: 4], combinational from registers. It is valid regardless of `blank`.
- Non-BCD nibbles (A-F) pass through unmodified; decoding is downstream.
- `en` deassert retains `active` and `pending`. Re-enable restarts at digit 0, GAP.

## Timing
- Reset values:
  - State IDLE, prescaler 0, `twobitcounter`=0, `blank`=1, `frame_done`=0, `update_pending`=0.
  - `active`=0 and `pending`=0, so `digit_bcd`=0.
- Reset takes priority over `en` and `load` in the same cycle. Mid-scan reset discards the pending value.
- Latencies, counting cycle 0 as the cycle `en`=1 is sampled in IDLE:
  - `blank` falls at cycle BLANK_CYCLES+1.
  - First digit advance is at cycle PRESCALE+1.
- `twobitcounter` changes only on the same edge on which `blank` rises. The anode therefore never switches while segments are lit.
- IDLE load latency is 1 cycle to `digit_bcd`. Scanning load latency is up to one frame, visible from the first slot of the next frame.
- Output `twobitcounter` never exceeds NUM_DIGITS-1.

## Test plan
Parameters for all scenarios: PRESCALE=8, BLANK_CYCLES=2, NUM_DIGITS=3.
- **Reset/idle:** reset 2 cycles, en=0 -> blank=1, twobitcounter=0, digit_bcd=0, frame_done=0 held for 20 cycles.
- **Scan sequence:** load value=12'h321 in IDLE, then en=1 ->
  - twobitcounter 0,1,2,0 in 8-cycle slots.
  - digit_bcd 1,2,3; blank high for 2 cycles at each slot start.
  - frame_done pulses once every 24 cycles.
- **Tear-free update:** while scanning digit 1, load 12'h987 -> update_pending=1 and displayed digits stay 1,2,3 to frame end. Next frame shows 7,8,9 and update_pending=0.
- **Simultaneous load and commit:** pending=12'h555 and load=12'h666 on the wrap edge ->
  - The next frame shows 5s with update_pending=1.
  - The following frame shows 6s.
- **Enable drop:** en=0 mid-SHOW on digit 2 -> next cycle IDLE with blank=1, twobitcounter=0 and no frame_done. Re-enable -> blank for 2 cycles, then digit 0.
- **Reset mid-operation:** reset during GAP with pending valid -> all outputs return to reset values and update_pending=0.
